// File: rtl/inv_key_schedule.sv
// inv_key_schedule: walks the AES-128 key schedule backwards, presenting the
// round keys 10 down to 0 over a valid/ready handshake.
// Build macro INV_KEY_SBOX_REG_EN: registers the SubWord output and spends one
// STALL cycle (keyValid low) per backward step; key values are unchanged.
//
// state   | meaning
// IDLE    | waiting for start; roundKey/roundNo hold their last values
// PRESENT | roundKey/roundNo valid, waiting for ready
// STEP    | round-0 key accepted; done pulses here, then back to IDLE
// STALL   | (macro only) registered SubWord in use, next key loads at exit

module inv_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] lastKey,
    input  logic         ready,
    output logic         keyValid,
    output logic [127:0] roundKey,
    output logic [3:0]   roundNo,
    output logic         busy,
    output logic         done
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef INV_KEY_SBOX_REG_EN
    typedef enum logic [1:0] {IDLE, PRESENT, STEP, STALL} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRESENT, STEP} state_t;
`endif

    state_t         r_state;
    logic [127:0]   r_round_key;
    logic [3:0]     r_round_no;
    logic           r_key_valid;
    logic           r_busy;
    logic           r_done;

    logic [31:0]    w_a, w_b, w_c, w_d;
    logic [31:0]    w_a_n, w_b_n, w_c_n, w_d_n;
    logic [31:0]    w_rot, w_sub, w_sub_use;
    logic [7:0]     w_rcon;
    logic [127:0]   w_prev_key;

    // Backward step: recover the previous round's words from the current key.
    assign {w_a, w_b, w_c, w_d} = r_round_key;
    assign w_d_n = w_d ^ w_c;
    assign w_c_n = w_c ^ w_b;
    assign w_b_n = w_b ^ w_a;
    assign w_rot = {w_d_n[23:0], w_d_n[31:24]};
    assign w_sub = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]],
                    SBOX[w_rot[15:8]],  SBOX[w_rot[7:0]]};

`ifdef INV_KEY_SBOX_REG_EN
    logic [31:0] r_sub;
    assign w_sub_use = r_sub;
`else
    assign w_sub_use = w_sub;
`endif

    assign w_a_n      = w_a ^ w_sub_use ^ {w_rcon, 24'h0};
    assign w_prev_key = {w_a_n, w_b_n, w_c_n, w_d_n};

    // Round constant of the round currently presented (the one being undone).
    always_comb begin
        w_rcon = 8'h00;
        case (r_round_no)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Sequencer: accepts start, presents keys, steps on each handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_round_key <= '0;
            r_round_no  <= '0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef INV_KEY_SBOX_REG_EN
            r_sub       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_round_key <= lastKey;
                        r_round_no  <= 4'd10;
                        r_key_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ready) begin
                        if (r_round_no == 4'd0) begin
                            r_key_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= STEP;
                        end else begin
`ifdef INV_KEY_SBOX_REG_EN
                            r_sub       <= w_sub;
                            r_key_valid <= 1'b0;
                            r_state     <= STALL;
`else
                            r_round_key <= w_prev_key;
                            r_round_no  <= r_round_no - 4'd1;
`endif
                        end
                    end
                end
                STEP: begin
                    r_state <= IDLE;
                end
`ifdef INV_KEY_SBOX_REG_EN
                STALL: begin
                    r_round_key <= w_prev_key;
                    r_round_no  <= r_round_no - 4'd1;
                    r_key_valid <= 1'b1;
                    r_state     <= PRESENT;
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign keyValid = r_key_valid;
    assign roundKey = r_round_key;
    assign roundNo  = r_round_no;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
